vga_pattern_gen: RTL and testbench

//  Parametrised VGA test-pattern generator driven by the hsync/vsync counter block's hc/vc/vidon.

---
 rtl/vga_pattern_gen.sv | 92 +++++++++
 tb/tb_vga_pattern_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern generator with frame-synchronous mode switching
module vga_pattern_gen #(
    parameter int COLOR_W     = 4,
    parameter int STRIPE_LOG2 = 4,
    parameter int CNT_W       = 11,
    parameter int SCROLL_DIV  = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               vidon,
    input  logic [CNT_W-1:0]   hc,
    input  logic [CNT_W-1:0]   vc,
    input  logic [1:0]         mode_req,
    input  logic               mode_stb,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [1:0]         mode_act,
    output logic               frame_tick
);

    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    localparam logic [1:0] MODE_HSTRIPE = 2'd0;
    localparam logic [1:0] MODE_VSTRIPE = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_SCROLL  = 2'd3;

    logic [1:0]       mode_pend;
    logic             pend_vld;
    logic [CNT_W-1:0] offset;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] vsum;
    logic             fb;
    logic             s;

    assign fb   = (hc == '0) && (vc == '0);
    assign vsum = vc + offset;

    always_comb begin
        s = 1'b0;
        case (mode_act)
            MODE_HSTRIPE: s = vc[STRIPE_LOG2];
            MODE_VSTRIPE: s = hc[STRIPE_LOG2];
            MODE_CHECKER: s = hc[STRIPE_LOG2] ^ vc[STRIPE_LOG2];
            MODE_SCROLL:  s = vsum[STRIPE_LOG2];
            default:      s = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            mode_act   <= MODE_HSTRIPE;
            mode_pend  <= MODE_HSTRIPE;
            pend_vld   <= 1'b0;
            offset     <= '0;
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else begin
            red        <= (vidon && s) ? '1 : '0;
            green      <= (vidon && s) ? '1 : '0;
            blue       <= '0;
            frame_tick <= fb;

            // A strobe landing on the boundary itself bypasses the pending slot.
            if (fb) begin
                if (mode_stb)
                    mode_act <= mode_req;
                else if (pend_vld)
                    mode_act <= mode_pend;
                pend_vld <= 1'b0;
            end else if (mode_stb) begin
                mode_pend <= mode_req;
                pend_vld  <= 1'b1;
            end

            if (fb) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    offset  <= offset + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed bench for vga_pattern_gen
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        clr;
    logic        vidon;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [1:0]  mode_req;
    logic        mode_stb;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [1:0]  mode_act;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] YEL = 32'hFF0;
    localparam logic [31:0] BLK = 32'h000;

    vga_pattern_gen #(
        .COLOR_W(4), .STRIPE_LOG2(4), .CNT_W(11), .SCROLL_DIV(2)
    ) dut (
        .clk(clk), .clr(clr), .vidon(vidon), .hc(hc), .vc(vc),
        .mode_req(mode_req), .mode_stb(mode_stb),
        .red(red), .green(green), .blue(blue),
        .mode_act(mode_act), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {20'd0, red, green, blue};
    endfunction

    task automatic fb_cycle();
        hc = 11'd0; vc = 11'd0;
        step();
        hc = 11'd5; vc = 11'd20;
        step();
    endtask

    initial begin
        clr = 1'b1; vidon = 1'b1; hc = 11'd5; vc = 11'd16;
        mode_req = 2'd0; mode_stb = 1'b0;

        // T1 reset
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_rgb", rgb(), BLK);
            chk("t1_mode", {30'd0, mode_act}, 32'd0);
            chk("t1_tick", {31'd0, frame_tick}, 32'd0);
        end
        clr = 1'b0;

        // T2 horizontal stripes
        vc = 11'd15; step(); chk("t2_vc15", rgb(), BLK);
        vc = 11'd16; step(); chk("t2_vc16", rgb(), YEL);
        vc = 11'd15; step(); chk("t2_vc15b", rgb(), BLK);
        vidon = 1'b0; vc = 11'd16; step(); chk("t2_blank", rgb(), BLK);
        vidon = 1'b1;

        // T3 deferred mode change
        hc = 11'd5; vc = 11'd20; mode_req = 2'd2; mode_stb = 1'b1; step();
        mode_stb = 1'b0;
        chk("t3_hold", {30'd0, mode_act}, 32'd0);
        chk("t3_pend", {31'd0, dut.pend_vld}, 32'd1);
        step(); chk("t3_hold2", {30'd0, mode_act}, 32'd0);
        hc = 11'd0; vc = 11'd0; step();
        chk("t3_apply", {30'd0, mode_act}, 32'd2);
        chk("t3_tick", {31'd0, frame_tick}, 32'd1);
        chk("t3_fbpix", rgb(), BLK);
        hc = 11'd16; vc = 11'd16; step();
        chk("t3_chk11", rgb(), BLK);
        chk("t3_tick0", {31'd0, frame_tick}, 32'd0);
        hc = 11'd16; vc = 11'd0; step();
        chk("t3_chk10", rgb(), YEL);

        // T4 last wins, then strobe on the boundary
        hc = 11'd5; vc = 11'd20;
        mode_req = 2'd1; mode_stb = 1'b1; step();
        mode_req = 2'd3; step();
        mode_stb = 1'b0; step();
        chk("t4_hold", {30'd0, mode_act}, 32'd2);
        hc = 11'd0; vc = 11'd0; step();
        chk("t4_last", {30'd0, mode_act}, 32'd3);
        hc = 11'd5; vc = 11'd20; step();
        hc = 11'd0; vc = 11'd0; mode_req = 2'd1; mode_stb = 1'b1; step();
        mode_stb = 1'b0;
        chk("t4_simul", {30'd0, mode_act}, 32'd1);
        chk("t4_pend0", {31'd0, dut.pend_vld}, 32'd0);
        hc = 11'd5; vc = 11'd20; step();
        fb_cycle();
        chk("t4_noreq", {30'd0, mode_act}, 32'd1);

        // T5 scrolling from a clean reset
        clr = 1'b1; step(); clr = 1'b0;
        chk("t5_off0", {21'd0, dut.offset}, 32'd0);
        hc = 11'd5; vc = 11'd20; mode_req = 2'd3; mode_stb = 1'b1; step();
        mode_stb = 1'b0;
        fb_cycle();
        chk("t5_mode", {30'd0, mode_act}, 32'd3);
        chk("t5_off_f1", {21'd0, dut.offset}, 32'd0);
        vc = 11'd15; step(); chk("t5_pix_f1", rgb(), BLK);
        fb_cycle();
        chk("t5_off_f2", {21'd0, dut.offset}, 32'd1);
        vc = 11'd15; step(); chk("t5_pix_f2", rgb(), YEL);
        fb_cycle();
        chk("t5_off_f3", {21'd0, dut.offset}, 32'd1);
        vc = 11'd14; step(); chk("t5_pix_f3", rgb(), BLK);
        fb_cycle();
        chk("t5_off_f4", {21'd0, dut.offset}, 32'd2);
        vc = 11'd14; step(); chk("t5_pix_f4", rgb(), YEL);
        for (int i = 0; i < 2045 * 2; i++) fb_cycle();
        chk("t5_off_max", {21'd0, dut.offset}, 32'd2047);
        vc = 11'd1; step(); chk("t5_wrap_blk", rgb(), BLK);
        vc = 11'd17; step(); chk("t5_wrap_yel", rgb(), YEL);
        fb_cycle(); fb_cycle();
        chk("t5_off_wrap", {21'd0, dut.offset}, 32'd0);

        // T6 reset mid-operation with a pending request
        fb_cycle(); fb_cycle();
        chk("t6_off1", {21'd0, dut.offset}, 32'd1);
        hc = 11'd5; vc = 11'd20; mode_req = 2'd2; mode_stb = 1'b1; step();
        mode_stb = 1'b0;
        chk("t6_pend1", {31'd0, dut.pend_vld}, 32'd1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t6_off", {21'd0, dut.offset}, 32'd0);
        chk("t6_pend", {31'd0, dut.pend_vld}, 32'd0);
        chk("t6_mode", {30'd0, mode_act}, 32'd0);
        hc = 11'd0; vc = 11'd0; step();
        chk("t6_noapply", {30'd0, mode_act}, 32'd0);
        chk("t6_tick", {31'd0, frame_tick}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
